ibuf2axis: RTL and testbench
============================

Name: ibuf2axis

Overview:
- Drain stage directly downstream of the backend-to-ibuf writer.
- Reads committed packets out of the shared internal buffer (ibuf) through the ibuf read port.
- Each packet is a header word followed by data words. The block reformats them into a 64-bit AXI4-Stream master toward the host forwarding logic.
- Returns freed ibuf space to the writer by advancing committed_cons.

Parameters:
BW, 10, ibuf address width; ibuf depth 2**BW words; pointers are BW+1 bits (MSB = wrap bit).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
en  in  1  drain enable; when low, no new packet is started
committed_prod  in  BW+1  writer pointer; next header slot, all slots before it committed
committed_cons  out  BW+1  consumer pointer; next header slot to be read
rd_addr  out  BW  ibuf read address
rd_data  in  64  ibuf read data, valid exactly 1 clk after rd_addr
m_axis_tdata  out  64  packet data
m_axis_tstrb  out  8  byte strobes
m_axis_tuser  out  128  [15:0] len, [23:16] src_port, [31:24] des_port, rest 0
m_axis_tvalid  out  1  AXIS valid
m_axis_tlast  out  1  last beat of packet
m_axis_tready  in  1  AXIS ready
activity  out  1  one-cycle pulse per packet committed back

Behaviour:
- Reset, asynchronous: committed_cons=0, rd_addr=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata/tstrb/tuser=0, activity=0, FSM=IDLE, output FIFO empty.
- committed_prod is registered once internally (prod_r) before any compare.
- Header word layout: len=[47:32], des_port=[23:16], src_port=[7:0]; all other bits ignored.
- nwords = (len+7)>>3, 13 bits. len==0 is treated as nwords=1 because the writer always writes at least one data word.
- Data words sit at cons+1 .. cons+nwords. The next header is at cons+nwords+1. All pointer math is modulo 2**(BW+1); rd_addr is the low BW bits, so wrap-around is natural.
- FSM states:
  - IDLE: if en && prod_r != committed_cons, drive rd_addr=committed_cons[BW-1:0] and go to HDR_WAIT.
  - HDR_WAIT: the rd_data header is captured in the next cycle. Latch len/src/des, compute nwords, set rd_ptr=cons+1, remaining=nwords, go to DATA.
  - DATA: issue one read per cycle, rd_addr=rd_ptr, only while (fifo_count + reads_in_flight) < 2. Each returning word is pushed into a 2-entry output FIFO with tlast=(word index==nwords) and the tuser fields. After the final read is issued, go to DRAIN.
  - DRAIN: wait for the handshake on the tlast beat, m_axis_tvalid && m_axis_tready && m_axis_tlast.
  - COMMIT: committed_cons <= committed_cons+nwords+1, activity=1 for one cycle, return to IDLE.
- tstrb: 0xFF on all non-last beats. On the last beat: len[2:0]==0 gives 0xFF, otherwise (1<<len[2:0])-1. len==0 gives 0x00.
- AXIS rules:
  - m_axis_tvalid is asserted iff the FIFO is non-empty.
  - tdata/tstrb/tuser/tlast are held stable while tvalid && !tready.
  - FIFO pop happens on tvalid && tready.
  - Zero bubbles when tready is held high: 1 beat/clk sustained after the first word.
- Latency: prod_r change to first m_axis_tvalid is 5 clk with tready=1 (1 reg + IDLE + HDR_WAIT + read + FIFO).
- en deasserted mid-packet has no effect; the current packet completes. en is sampled only in IDLE.
- A committed_prod change during a packet is ignored until IDLE.
- committed_cons never passes prod_r. committed_cons is updated only after the last beat is accepted, so the writer never overwrites unsent data.
- Back-to-back packets: IDLE may re-evaluate in the cycle after COMMIT. Minimum gap between packets is 2 clk (COMMIT, IDLE/HDR_WAIT).

Decomposition:
- Shared package ibuf_pkg holds the header field offsets (HDR_LEN_LSB=32, HDR_DES_LSB=16, HDR_SRC_LSB=0), the tuser field offsets, and FSM state encodings. The writer stage uses the same definitions.
- One sub-module: ibuf2axis_ofifo, a 2-entry register FIFO carrying {tdata, tstrb, tlast, tuser} with count output. The parent FSM and read-credit logic stay in ibuf2axis.

Test Plan:
- Single packet: ibuf[0] header len=64, src=1, des=2; data at 1..8; committed_prod 0→9; tready=1 -> 8 beats, tstrb=0xFF on all beats, tlast on beat 8, tuser[31:0]=0x0201_0040, committed_cons=9, one activity pulse.
- Odd length: len=13 -> 2 beats, last tstrb=0x1F, committed_cons advances by 3.
- Backpressure: len=32, tready toggled 1/0 each clk -> 4 beats, data is correct and stable while stalled, no drop or duplicate, committed_cons changes only after the tlast handshake.
- Wrap-around: BW=4, cons=14, header at 14, len=24 -> reads addresses 15, 0, 1; committed_cons=18 (binary 1_0010).
- Back-to-back: two packets committed at once (prod=9+3) -> second header read within 2 clk after COMMIT, final committed_cons=12.
- Async reset asserted mid-DATA -> all outputs return to their reset values immediately, with no clk edge needed; after release with en=1 the block restarts from cons=0.

Source files
------------

// File: rtl/ibuf_pkg.sv
// rtl/ibuf_pkg.sv - shared ibuf header layout, AXIS tuser layout and drain FSM encodings
//
// Used by the ibuf writer and by ibuf2axis so both sides agree on where the
// header fields live.
package ibuf_pkg;

    // Header word field offsets
    localparam int HDR_LEN_LSB = 32;
    localparam int HDR_DES_LSB = 16;
    localparam int HDR_SRC_LSB = 0;

    // m_axis_tuser field offsets; all other tuser bits are zero
    localparam int TUSER_LEN_LSB = 0;
    localparam int TUSER_SRC_LSB = 16;
    localparam int TUSER_DES_LSB = 24;

    // Drain FSM encodings
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_HDR_WAIT = 3'd1;
    localparam logic [2:0] ST_DATA     = 3'd2;
    localparam logic [2:0] ST_DRAIN    = 3'd3;
    localparam logic [2:0] ST_COMMIT   = 3'd4;

    // One output FIFO entry
    typedef struct packed {
        logic [63:0]  tdata;
        logic [7:0]   tstrb;
        logic         tlast;
        logic [127:0] tuser;
    } ofifo_entry_t;

    // Number of data words following a header. The writer always stores at
    // least one data word, so a zero-length packet still occupies one slot.
    function automatic logic [12:0] nwords_of(input logic [15:0] len);
        logic [16:0] sum;
        sum = {1'b0, len} + 17'd7;
        if (len == 16'd0) begin
            return 13'd1;
        end
        return 13'(sum >> 3);
    endfunction

    // Byte strobes for the final beat of a packet
    function automatic logic [7:0] last_strb_of(input logic [15:0] len);
        if (len == 16'd0) begin
            return 8'h00;
        end
        if (len[2:0] == 3'd0) begin
            return 8'hFF;
        end
        return (8'd1 << len[2:0]) - 8'd1;
    endfunction

endpackage

// File: rtl/ibuf2axis_ofifo.sv
// rtl/ibuf2axis_ofifo.sv - 2-entry register FIFO holding AXIS beats for ibuf2axis
//
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   push       write push_data (caller guarantees space, counting a same-cycle pop)
//   push_data  {tdata, tstrb, tlast, tuser}
//   pop        drop the head entry
//   head       current head entry; unchanged until popped
//   count      number of valid entries (0..2)
module ibuf2axis_ofifo
    import ibuf_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  ofifo_entry_t push_data,
    input  logic         pop,
    output ofifo_entry_t head,
    output logic [1:0]   count
);

    ofifo_entry_t mem0;
    ofifo_entry_t mem1;
    logic         wr_sel;
    logic         rd_sel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem0   <= '0;
            mem1   <= '0;
            wr_sel <= 1'b0;
            rd_sel <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                if (wr_sel) begin
                    mem1 <= push_data;
                end else begin
                    mem0 <= push_data;
                end
                wr_sel <= ~wr_sel;
            end
            if (pop) begin
                rd_sel <= ~rd_sel;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // A push only ever lands in the slot not being presented, except when the
    // FIFO is empty, so the head is stable while tvalid is high.
    assign head = rd_sel ? mem1 : mem0;

endmodule

// File: rtl/ibuf2axis.sv
// rtl/ibuf2axis.sv - drains committed ibuf packets onto a 64-bit AXI4-Stream master
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   en                drain enable, sampled only between packets
//   committed_prod    writer pointer (BW+1 bits, MSB is the wrap bit)
//   committed_cons    consumer pointer, advanced after a packet's tlast is accepted
//   rd_addr, rd_data  ibuf read port, data returns one clock after the address
//   m_axis_*          AXI4-Stream master; tuser = {des, src, len} in the low 32 bits
//   activity          one-cycle pulse per packet returned to the writer
module ibuf2axis
    import ibuf_pkg::*;
#(
    parameter int BW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [BW:0]   committed_prod,
    output logic [BW:0]   committed_cons,
    output logic [BW-1:0] rd_addr,
    input  logic [63:0]   rd_data,
    output logic [63:0]   m_axis_tdata,
    output logic [7:0]    m_axis_tstrb,
    output logic [127:0]  m_axis_tuser,
    output logic          m_axis_tvalid,
    output logic          m_axis_tlast,
    input  logic          m_axis_tready,
    output logic          activity
);

    localparam int PW = BW + 1;

    logic [2:0]    state;
    logic [BW:0]   prod_r;
    logic [15:0]   len_r;
    logic [7:0]    src_r;
    logic [7:0]    des_r;
    logic [12:0]   nwords_r;
    logic [12:0]   remaining;
    logic [BW:0]   rd_ptr;
    logic          rd_pend;
    logic          rd_pend_last;

    logic          pop;
    logic          issue;
    logic [1:0]    fifo_count;
    logic [2:0]    credit_used;
    logic [2:0]    credit_lim;
    logic [15:0]   hdr_len;
    ofifo_entry_t  push_data;
    ofifo_entry_t  head;

    assign pop = m_axis_tvalid & m_axis_tready;

    // A read may be issued while the FIFO, counting the read already in
    // flight, still has a free slot at the time its data arrives. Crediting a
    // same-cycle pop keeps the stream bubble-free with tready held high.
    assign credit_used = {1'b0, fifo_count} + {2'b00, rd_pend};
    assign credit_lim  = 3'd2 + {2'b00, pop};
    assign issue = (state == ST_DATA) && (remaining != 13'd0) && (credit_used < credit_lim);

    // In IDLE the header slot is presented so its word is ready in HDR_WAIT.
    assign rd_addr = (state == ST_IDLE) ? committed_cons[BW-1:0] : rd_ptr[BW-1:0];

    assign hdr_len = rd_data[HDR_LEN_LSB +: 16];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            prod_r         <= '0;
            committed_cons <= '0;
            len_r          <= '0;
            src_r          <= '0;
            des_r          <= '0;
            nwords_r       <= '0;
            remaining      <= '0;
            rd_ptr         <= '0;
            rd_pend        <= 1'b0;
            rd_pend_last   <= 1'b0;
            activity       <= 1'b0;
        end else begin
            prod_r       <= committed_prod;
            rd_pend      <= issue;
            rd_pend_last <= issue && (remaining == 13'd1);
            activity     <= (state == ST_COMMIT);
            case (state)
                ST_IDLE: begin
                    if (en && (prod_r != committed_cons)) begin
                        state <= ST_HDR_WAIT;
                    end
                end
                ST_HDR_WAIT: begin
                    len_r     <= hdr_len;
                    src_r     <= rd_data[HDR_SRC_LSB +: 8];
                    des_r     <= rd_data[HDR_DES_LSB +: 8];
                    nwords_r  <= nwords_of(hdr_len);
                    remaining <= nwords_of(hdr_len);
                    rd_ptr    <= committed_cons + PW'(1);
                    state     <= ST_DATA;
                end
                ST_DATA: begin
                    if (issue) begin
                        rd_ptr    <= rd_ptr + PW'(1);
                        remaining <= remaining - 13'd1;
                        if (remaining == 13'd1) begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (pop && m_axis_tlast) begin
                        state <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    committed_cons <= committed_cons + PW'(nwords_r) + PW'(1);
                    state          <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        push_data       = '0;
        push_data.tdata = rd_data;
        push_data.tlast = rd_pend_last;
        push_data.tstrb = rd_pend_last ? last_strb_of(len_r) : 8'hFF;
        push_data.tuser[TUSER_LEN_LSB +: 16] = len_r;
        push_data.tuser[TUSER_SRC_LSB +: 8]  = src_r;
        push_data.tuser[TUSER_DES_LSB +: 8]  = des_r;
    end

    ibuf2axis_ofifo u_ofifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rd_pend),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count)
    );

    assign m_axis_tvalid = (fifo_count != 2'd0);
    assign m_axis_tdata  = head.tdata;
    assign m_axis_tstrb  = head.tstrb;
    assign m_axis_tlast  = head.tlast;
    assign m_axis_tuser  = head.tuser;

endmodule

// File: tb/tb_ibuf2axis.sv
// tb/tb_ibuf2axis.sv - randomized self-checking bench for ibuf2axis (BW=4)
module tb_ibuf2axis;

    localparam int BW    = 4;
    localparam int DEPTH = 16;
    localparam int PMOD  = 32;

    typedef struct packed {
        logic [63:0] tdata;
        logic [7:0]  tstrb;
        logic        tlast;
        logic [31:0] tuser;
    } exp_beat_t;

    typedef struct packed {
        logic [4:0]  cons;
        logic [31:0] beats;
    } exp_commit_t;

    logic          clk;
    logic          rst;
    logic          en;
    logic [BW:0]   committed_prod;
    logic [BW:0]   committed_cons;
    logic [BW-1:0] rd_addr;
    logic [63:0]   rd_data;
    logic [63:0]   m_axis_tdata;
    logic [7:0]    m_axis_tstrb;
    logic [127:0]  m_axis_tuser;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic          m_axis_tready;
    logic          activity;

    ibuf2axis #(.BW(BW)) dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .committed_prod (committed_prod),
        .committed_cons (committed_cons),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tstrb   (m_axis_tstrb),
        .m_axis_tuser   (m_axis_tuser),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tready  (m_axis_tready),
        .activity       (activity)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ibuf model: synchronous read, data one clock after the address
    logic [63:0] mem [0:DEPTH-1];
    always @(posedge clk) rd_data <= mem[rd_addr];

    // tready pattern: 0 always high, 1 toggling, 2 random, 3 held low
    int rdy_mode = 0;
    initial begin
        m_axis_tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       m_axis_tready = 1'b1;
                1:       m_axis_tready = ~m_axis_tready;
                2:       m_axis_tready = 1'($urandom_range(0, 1));
                default: m_axis_tready = 1'b0;
            endcase
        end
    end

    // Reference model state
    exp_beat_t   exp_q[$];
    exp_commit_t commit_q[$];
    int          wp = 0;
    int          total_beats = 0;
    int          beats_acc = 0;
    int          act_cnt = 0;
    logic [4:0]  model_cons = '0;

    function automatic logic [7:0] exp_last_strb(input int len);
        if (len == 0) return 8'h00;
        if (len % 8 == 0) return 8'hFF;
        return 8'((1 << (len % 8)) - 1);
    endfunction

    // Writer: stores a header plus data words at wp and records what must come out
    task automatic write_pkt(input int len, input logic [7:0] src, input logic [7:0] des);
        int          nw;
        logic [63:0] h;
        logic [63:0] d;
        exp_beat_t   b;
        exp_commit_t c;
        nw = (len == 0) ? 1 : (len + 7) / 8;
        h = {$urandom, $urandom};
        h[47:32] = 16'(len);
        h[23:16] = des;
        h[7:0]   = src;
        mem[wp % DEPTH] = h;
        for (int i = 1; i <= nw; i++) begin
            d = {$urandom, $urandom};
            mem[(wp + i) % DEPTH] = d;
            b.tdata = d;
            b.tlast = (i == nw);
            b.tstrb = (i < nw) ? 8'hFF : exp_last_strb(len);
            b.tuser = {des, src, 16'(len)};
            exp_q.push_back(b);
        end
        total_beats += nw;
        wp = (wp + nw + 1) % PMOD;
        c.cons  = 5'(wp);
        c.beats = 32'(total_beats);
        commit_q.push_back(c);
    endtask

    task automatic publish();
        @(posedge clk);
        #1;
        committed_prod = 5'(wp);
    endtask

    task automatic wait_drain();
        int cnt = 0;
        while ((exp_q.size() != 0 || commit_q.size() != 0) && cnt < 3000) begin
            @(posedge clk);
            cnt++;
        end
        if (exp_q.size() != 0 || commit_q.size() != 0) begin
            check("drain_timeout", 1, 0);
            exp_q.delete();
            commit_q.delete();
        end
        repeat (2) @(posedge clk);
    endtask

    // Stream and pointer monitor, sampled mid-cycle
    initial begin
        exp_beat_t   mb;
        exp_commit_t mc;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (m_axis_tvalid) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_beat", 1, 0);
                    end else begin
                        mb = exp_q[0];
                        check("tdata", m_axis_tdata, mb.tdata);
                        check("tstrb", m_axis_tstrb, mb.tstrb);
                        check("tlast", m_axis_tlast, mb.tlast);
                        check("tuser", m_axis_tuser, {96'd0, mb.tuser});
                        if (m_axis_tready) begin
                            void'(exp_q.pop_front());
                            beats_acc++;
                        end
                    end
                end
                if (activity) begin
                    act_cnt++;
                    if (commit_q.size() == 0) begin
                        check("spurious_commit", 1, 0);
                    end else begin
                        mc = commit_q.pop_front();
                        check("commit_after_last", (beats_acc >= int'(mc.beats)), 1);
                        model_cons = mc.cons;
                    end
                end
                check("committed_cons", committed_cons, model_cons);
            end
        end
    end

    initial begin
        int  lat;
        int  n;
        int  gaps;
        int  cnt;
        int  npk;
        logic saw;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        rst = 1'b1;
        en = 1'b0;
        committed_prod = '0;
        rdy_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_tlast", m_axis_tlast, 0);
        check("rst_tdata", m_axis_tdata, 0);
        check("rst_tstrb", m_axis_tstrb, 0);
        check("rst_tuser", m_axis_tuser, 0);
        check("rst_cons", committed_cons, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_activity", activity, 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        en = 1'b1;

        // Single packet: latency, bubble-free burst, tuser value
        write_pkt(64, 8'h01, 8'h02);
        publish();
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!m_axis_tvalid && lat < 50);
        check("first_valid_latency", lat, 5);
        check("pkt1_tuser", m_axis_tuser[31:0], 32'h0201_0040);
        n = 0;
        gaps = 0;
        while (n < 50) begin
            n++;
            if (!m_axis_tvalid) gaps++;
            if (m_axis_tvalid && m_axis_tlast) break;
            @(posedge clk);
            #1;
        end
        check("burst_cycles", n, 8);
        check("burst_gaps", gaps, 0);
        wait_drain();
        check("pkt1_cons", committed_cons, 9);
        check("pkt1_activity_count", act_cnt, 1);

        // Odd length
        write_pkt(13, 8'h03, 8'h04);
        publish();
        wait_drain();
        check("odd_cons", committed_cons, 12);

        // en low holds off a committed packet
        en = 1'b0;
        write_pkt(8, 8'h05, 8'h06);
        publish();
        saw = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (m_axis_tvalid) saw = 1'b1;
        end
        check("en_low_no_start", saw, 0);
        en = 1'b1;
        wait_drain();
        check("en_cons", committed_cons, 14);

        // Wrap-around: header at 14, data at 15, 0, 1
        write_pkt(24, 8'h07, 8'h08);
        publish();
        wait_drain();
        check("wrap_cons", committed_cons, 5'b1_0010);

        // Back-to-back: second header presented right after the first commit
        write_pkt(64, 8'h11, 8'h22);
        write_pkt(13, 8'h33, 8'h44);
        publish();
        cnt = 0;
        while (cnt < 500) begin
            @(negedge clk);
            cnt++;
            if (activity) break;
        end
        check("b2b_first_commit_seen", (cnt < 500), 1);
        check("b2b_next_hdr_addr", rd_addr, 4'd11);
        wait_drain();
        check("b2b_cons", committed_cons, 30);

        // Backpressure with tready toggling every clock
        rdy_mode = 1;
        write_pkt(32, 8'h55, 8'h66);
        publish();
        wait_drain();
        check("bp_cons", committed_cons, 3);
        rdy_mode = 0;

        // Asynchronous reset in the middle of a stalled packet
        rdy_mode = 3;
        write_pkt(64, 8'h77, 8'h88);
        publish();
        cnt = 0;
        while (!m_axis_tvalid && cnt < 100) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check("stall_valid_seen", m_axis_tvalid, 1);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_tvalid", m_axis_tvalid, 0);
        check("arst_tlast", m_axis_tlast, 0);
        check("arst_tdata", m_axis_tdata, 0);
        check("arst_tstrb", m_axis_tstrb, 0);
        check("arst_tuser", m_axis_tuser, 0);
        check("arst_cons", committed_cons, 0);
        check("arst_rd_addr", rd_addr, 0);
        check("arst_activity", activity, 0);
        exp_q.delete();
        commit_q.delete();
        wp = 0;
        total_beats = 0;
        beats_acc = 0;
        model_cons = '0;
        committed_prod = '0;
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        write_pkt(20, 8'h99, 8'hAA);
        publish();
        wait_drain();
        check("restart_cons", committed_cons, 4);

        // Randomized batches with random backpressure and enable
        for (int it = 0; it < 40; it++) begin
            rdy_mode = $urandom_range(0, 2);
            npk = $urandom_range(1, 3);
            for (int p = 0; p < npk; p++) begin
                write_pkt($urandom_range(0, 32), 8'($urandom), 8'($urandom));
            end
            en = ($urandom_range(0, 3) != 0);
            publish();
            if (!en) begin
                repeat ($urandom_range(1, 8)) @(posedge clk);
                #1;
                en = 1'b1;
            end
            wait_drain();
        end
        rdy_mode = 0;
        repeat (4) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
